// File: rtl/idle_checker.sv
// Receive-side idle sequence checker: HUNT -> VERIFY -> LOCKED on clean idles, back to HUNT on errors.
// Optional /A/ gap check in VERIFY is built when IDLE_CHECKER_AGAP_EN is defined.
module idle_checker #(
    parameter int VERIFY_COUNT  = 64,
    parameter int ERR_THRESHOLD = 4,
    parameter int MAX_A_GAP     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic       rx_K,
    input  logic       rx_A,
    input  logic       rx_R,
    input  logic       clr_err,
    output logic       idle_seen,
    output logic       lane_verified,
    output logic       err_pulse,
    output logic       a_gap_err,
    output logic [7:0] err_count
);

    localparam int GoodW = $clog2(VERIFY_COUNT + 1);
    localparam int BadW  = $clog2(ERR_THRESHOLD + 1);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    if (VERIFY_COUNT < 2 || ERR_THRESHOLD < 1 || MAX_A_GAP < 1) begin : gen_param_check
        $error("idle_checker: illegal parameter values");
    end

    logic [1:0]       state_q, state_d;
    logic [GoodW-1:0] good_cnt_q, good_cnt_d;
    logic [BadW-1:0]  bad_cnt_q, bad_cnt_d;
    logic [7:0]       err_count_d;
    logic [7:0]       err_base;
    logic             err_d;
    logic             sym_illegal, sym_idle, sym_a;
    logic             gap_over;

    assign sym_illegal = (rx_K & rx_A) | (rx_K & rx_R) | (rx_A & rx_R);
    assign sym_idle    = (rx_K | rx_A | rx_R) & ~sym_illegal;
    assign sym_a       = rx_A & ~rx_K & ~rx_R;

`ifdef IDLE_CHECKER_AGAP_EN
    localparam int GapW = $clog2(MAX_A_GAP + 2);

    logic [GapW-1:0] a_gap_q, a_gap_d;
    logic            gap_err_d;

    // The next non-/A/ symbol would push the gap past the limit.
    assign gap_over  = ~sym_a & (a_gap_q == GapW'(MAX_A_GAP));
    assign gap_err_d = rx_valid & (state_q == ST_VERIFY) & gap_over;

    always_comb begin
        a_gap_d = '0;
        if (state_d == ST_VERIFY) begin
            if (!rx_valid) begin
                a_gap_d = a_gap_q;
            end else if (sym_a) begin
                a_gap_d = '0;
            end else begin
                a_gap_d = a_gap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_gap_q   <= '0;
            a_gap_err <= 1'b0;
        end else begin
            a_gap_q   <= a_gap_d;
            a_gap_err <= gap_err_d;
        end
    end
`else
    assign gap_over  = 1'b0;
    assign a_gap_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        err_d      = 1'b0;
        if (rx_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (sym_a) begin
                        state_d    = ST_VERIFY;
                        good_cnt_d = GoodW'(1);
                    end
                end
                ST_VERIFY: begin
                    if (gap_over || !sym_idle) begin
                        err_d      = 1'b1;
                        state_d    = ST_HUNT;
                        good_cnt_d = '0;
                    end else if (good_cnt_q == GoodW'(VERIFY_COUNT - 1)) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // good_cnt is reused here as the run length of consecutive legal symbols.
                    if (sym_illegal) begin
                        err_d      = 1'b1;
                        good_cnt_d = '0;
                        if (bad_cnt_q == BadW'(ERR_THRESHOLD - 1)) begin
                            state_d   = ST_HUNT;
                            bad_cnt_d = '0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 1'b1;
                        end
                    end else if (good_cnt_q == GoodW'(VERIFY_COUNT - 1)) begin
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_HUNT;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end
            endcase
        end
    end

    // Clear takes effect first, so a clear coinciding with an error leaves a count of 1.
    always_comb begin
        err_base    = clr_err ? 8'd0 : err_count;
        err_count_d = err_base;
        if (err_d && err_base != 8'd255) begin
            err_count_d = err_base + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            idle_seen     <= 1'b0;
            lane_verified <= 1'b0;
            err_pulse     <= 1'b0;
            err_count     <= 8'd0;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            idle_seen     <= rx_valid & sym_idle;
            lane_verified <= (state_d == ST_LOCKED);
            err_pulse     <= err_d;
            err_count     <= err_count_d;
        end
    end

endmodule

// File: doc/idle_checker.md
# idle_checker

Receive-side counterpart of `idle_generator`. It consumes the per-cycle symbol classification from the lane's 8b/10b decoder (/K/, /A/, /R/ flags) and checks that the partner is sending a legal idle sequence. It declares the lane verified after enough clean idles, tracks symbol errors, and drops verification when errors accumulate. It sits between the RX decoder and lane/channel init logic, and `lane_verified` gates data transfer.

## Interface
Parameters:
- `VERIFY_COUNT`, default 64: number of consecutive clean idle symbols required in VERIFY before entering LOCKED (must be ≥ 2).
- `ERR_THRESHOLD`, default 4: number of errors in LOCKED that forces a return to HUNT (≥ 1).
- `MAX_A_GAP`, default 32: the largest legal number of valid symbols between two /A/ symbols while in VERIFY.

Ports:
- `clk` (in, 1): single clock, rising edge.
- `rst_n` (in, 1): asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `rx_valid` (in, 1): the decoder presents a symbol this cycle.
- `rx_K`, `rx_A`, `rx_R` (in, 1 each): symbol class flags, meaningful only when `rx_valid` is high.
- `clr_err` (in, 1): synchronous clear of `err_count`.
- `idle_seen` (out, 1): registered; high one cycle after a valid idle symbol is sampled.
- `lane_verified` (out, 1): registered; high exactly while the state is LOCKED.
- `err_pulse` (out, 1): one-cycle pulse for each detected error.
- `a_gap_err` (out, 1): one-cycle pulse when the /A/ gap limit is exceeded (subset of `err_pulse`).
- `err_count` (out, 8): saturating total error count since reset or since `clr_err`.

## Operation
Symbol classes, applied only when `rx_valid` is high:
- **Idle:** exactly one of K/A/R is set.
- **Data:** none of K/A/R is set.
- **Illegal:** more than one of K/A/R is set.

Cycles with `rx_valid` low are ignored entirely. No counter advances and no state changes.

State machine (HUNT, VERIFY, LOCKED). The reset state is HUNT.
- **HUNT:** wait for a valid /A/ (A-only). On that symbol, go to VERIFY with `good_cnt`=1 and `a_gap`=0. All other symbols are ignored and are not counted as errors.
- **VERIFY:**
  - An idle symbol increments `good_cnt`. When `good_cnt` reaches `VERIFY_COUNT`, go to LOCKED and clear `bad_cnt`.
  - An /A/ resets `a_gap` to 0. Any other valid symbol increments `a_gap`.
  - If `a_gap` would exceed `MAX_A_GAP`: raise `a_gap_err` and `err_pulse`, then go to HUNT.
  - A data or illegal symbol raises `err_pulse` and sends the FSM to HUNT.
- **LOCKED:**
  - Data and idle symbols are both legal.
  - An illegal symbol raises `err_pulse` and increments `bad_cnt`.
  - When `bad_cnt` reaches `ERR_THRESHOLD`, go to HUNT.
  - `VERIFY_COUNT` consecutive legal symbols clear `bad_cnt`.
  - There is no /A/ gap check in LOCKED.

Counter widths and arithmetic:
- `good_cnt` is `$clog2(VERIFY_COUNT+1)` bits. `a_gap` is `$clog2(MAX_A_GAP+2)` bits. Neither counter can wrap.
- `err_count` increments on every `err_pulse` and saturates at 255.
- If `clr_err` and `err_pulse` occur in the same cycle, the result is 1 (clear is applied, then the increment).

## Timing
- Reset values: every output is 0, the state is HUNT, and all counters are 0.
- Latency: one cycle from the sampled symbol to `idle_seen`, `err_pulse`, `a_gap_err` and `lane_verified` changes.
- `lane_verified` rises in the cycle after the `VERIFY_COUNT`-th idle is sampled.
- `lane_verified` falls in the cycle after the `ERR_THRESHOLD`-th illegal symbol is sampled.
- The erroring symbol in VERIFY is not re-examined as an /A/ for HUNT. HUNT waits for the next /A/.
- Asserting `rst_n` mid-operation clears everything immediately (asynchronously). The FSM resumes in HUNT on the first clock edge after deassertion.

## Configuration
- `IDLE_CHECKER_AGAP_EN` defined: the `a_gap` counter and the `MAX_A_GAP` check are built into VERIFY, as described above.
- Not defined: no gap counter is built. `a_gap_err` is tied to 0, and VERIFY only checks symbol classes. The port list is identical in both builds.

## Test plan
All scenarios use `VERIFY_COUNT`=64, `ERR_THRESHOLD`=4 and `MAX_A_GAP`=32, with the macro defined unless noted.

1. **Reset then stream:** reset, then drive /A/ followed by 63 K/R idles, with /A/ every 20 symbols. `lane_verified` rises one cycle after the 64th idle, `err_count`=0.
2. **Data during VERIFY:** drive /A/ plus 10 idles, then one data symbol. `err_pulse` fires once, the state returns to HUNT, `err_count`=1, and `lane_verified` stays 0.
3. **A-gap violation:** drive /A/ then 33 K symbols. `a_gap_err` and `err_pulse` pulse on the 33rd K, and the state goes to HUNT. Rebuilt without the macro: no error, and `lane_verified` rises after 64 idles.
4. **LOCKED error threshold:** from LOCKED, drive 4 illegal (K+A) symbols separated by 10 data symbols. `lane_verified` falls one cycle after the 4th, `err_count`=4. A separate run with 3 illegals, then 64 clean symbols, then 3 more illegals stays LOCKED.
5. **Counter edges:** inject 300 errors, and `err_count` holds at 255. Assert `clr_err` together with an error, and `err_count`=1.
6. **Stall and reset:** drop `rx_valid` for 10 cycles in VERIFY, and `good_cnt` holds, with lock still arriving after exactly 64 valid idles. Assert `rst_n`=0 while LOCKED, and all outputs read 0 with no clock edge needed.
